// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio prefilter saturating width reducer.
package audio_pkg;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;

  function automatic int unsigned hold_cnt_w(input int unsigned hold);
    return $clog2(hold + 1);
  endfunction

  // Clamp limits as bit patterns; callers truncate to their output width.
  function automatic logic [63:0] clamp_umax(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] clamp_smax(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] clamp_smin(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/audio_sat_lane.sv
// One audio channel: 2-stage saturating clamp plus clip hold counter.
module audio_sat_lane
  import audio_pkg::*;
#(
  parameter int unsigned IN          = 13,
  parameter int unsigned OUT         = 12,
  parameter int          SIGNED_MODE = MODE_UNSIGNED,
  parameter int unsigned CLIP_HOLD   = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           s1_valid,
  input  logic [IN-1:0]  din,
  output logic [OUT-1:0] dout,
  output logic           clip,
  output logic           clip_event
);

  localparam logic [OUT-1:0] UMAX = OUT'(clamp_umax(OUT));
  localparam logic [OUT-1:0] SMAX = OUT'(clamp_smax(OUT));
  localparam logic [OUT-1:0] SMIN = OUT'(clamp_smin(OUT));
  localparam int unsigned    HW   = hold_cnt_w(CLIP_HOLD);
  localparam logic [HW-1:0]  HOLD_LD = HW'(CLIP_HOLD);

  logic [IN-OUT:0] hi;
  logic            in_range;
  logic            ovf_d, udf_d;
  logic [OUT-1:0]  s1_data;
  logic            s1_ovf, s1_udf;
  logic [OUT-1:0]  sat;
  logic [HW-1:0]   hold_cnt;

  always_comb begin
    hi       = din[IN-1:OUT-1];
    in_range = (&hi) | ~(|hi);
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (SIGNED_MODE == MODE_SIGNED) begin
      ovf_d = !in_range && !din[IN-1];
      udf_d = !in_range &&  din[IN-1];
    end else begin
      ovf_d = |din[IN-1:OUT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data <= '0;
      s1_ovf  <= 1'b0;
      s1_udf  <= 1'b0;
    end else if (in_valid) begin
      s1_data <= din[OUT-1:0];
      s1_ovf  <= ovf_d;
      s1_udf  <= udf_d;
    end
  end

  always_comb begin
    sat = s1_data;
    if (s1_ovf)      sat = (SIGNED_MODE == MODE_SIGNED) ? SMAX : UMAX;
    else if (s1_udf) sat = SMIN;
  end

  assign clip_event = s1_valid && (s1_ovf || s1_udf);

  // clip samples the pre-update count, so it stays high for CLIP_HOLD clean samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= '0;
      clip     <= 1'b0;
      hold_cnt <= '0;
    end else if (s1_valid) begin
      dout <= sat;
      clip <= clip_event || (hold_cnt != '0);
      if (clip_event)           hold_cnt <= HOLD_LD;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
    end
  end

endmodule

// File: rtl/audio_prefilter_sat.sv
// Multi-channel pipelined saturating width reducer with clip indicators and clip counter.
module audio_prefilter_sat
  import audio_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned AUDIO_DW_IN  = 13,
  parameter int unsigned AUDIO_DW_OUT = 12,
  parameter int          SIGNED_MODE  = MODE_UNSIGNED,
  parameter int unsigned CLIP_HOLD    = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             din_valid,
  input  logic [CHANNELS*AUDIO_DW_IN-1:0]  din,
  output logic                             dout_valid,
  output logic [CHANNELS*AUDIO_DW_OUT-1:0] dout,
  output logic [CHANNELS-1:0]              clip,
  output logic [CNT_W-1:0]                 clip_cnt,
  input  logic                             clip_cnt_clr
);

  logic                v1, v2;
  logic [CHANNELS-1:0] clip_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= din_valid;
      v2 <= v1;
    end
  end

  assign dout_valid = v2;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    audio_sat_lane #(
      .IN          (AUDIO_DW_IN),
      .OUT         (AUDIO_DW_OUT),
      .SIGNED_MODE (SIGNED_MODE),
      .CLIP_HOLD   (CLIP_HOLD)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (din_valid),
      .s1_valid   (v1),
      .din        (din[c*AUDIO_DW_IN +: AUDIO_DW_IN]),
      .dout       (dout[c*AUDIO_DW_OUT +: AUDIO_DW_OUT]),
      .clip       (clip[c]),
      .clip_event (clip_event[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || clip_cnt_clr) begin
      clip_cnt <= '0;
    end else if (v1 && (|clip_event) && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_audio_prefilter_sat.sv
// Bench: unsigned and signed instances driven in parallel, checked against a sample-level model.
module tb_audio_prefilter_sat;

  localparam int H  = 4;
  localparam int NT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic        clip_cnt_clr = 1'b0;
  logic [25:0] din = '0;

  logic        dv_u, dv_s;
  logic [23:0] do_u, do_s;
  logic [1:0]  clip_u, clip_s;
  logic [3:0]  cnt_u, cnt_s;

  int total = 0;
  int bad   = 0;

  audio_prefilter_sat #(
    .CHANNELS(2), .AUDIO_DW_IN(13), .AUDIO_DW_OUT(12),
    .SIGNED_MODE(0), .CLIP_HOLD(H), .CNT_W(4)
  ) u_uns (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .dout_valid(dv_u), .dout(do_u), .clip(clip_u), .clip_cnt(cnt_u),
    .clip_cnt_clr(clip_cnt_clr)
  );

  audio_prefilter_sat #(
    .CHANNELS(2), .AUDIO_DW_IN(13), .AUDIO_DW_OUT(12),
    .SIGNED_MODE(1), .CLIP_HOLD(H), .CNT_W(4)
  ) u_sgn (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .dout_valid(dv_s), .dout(do_s), .clip(clip_s), .clip_cnt(cnt_s),
    .clip_cnt_clr(clip_cnt_clr)
  );

  always #5 clk = ~clk;

  // Reference model state: accepted sample waiting to emerge, plus visible outputs.
  int q1_v = 0;
  int q1_d[2];
  int e_dv = 0;
  int e_dout[2][2];
  int since[2][2];
  int e_cnt[2];

  function automatic int ref_out(input int mode, input int x);
    int v;
    if (mode == 0) return (x > 4095) ? 4095 : x;
    v = (x >= 4096) ? x - 8192 : x;
    if (v > 2047) v = 2047;
    else if (v < -2048) v = -2048;
    return v & 4095;
  endfunction

  function automatic bit ref_clip(input int mode, input int x);
    int v;
    if (mode == 0) return x > 4095;
    v = (x >= 4096) ? x - 8192 : x;
    return (v > 2047) || (v < -2048);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1_v = 0;
    e_dv = 0;
    for (int m = 0; m < 2; m++) begin
      e_cnt[m] = 0;
      for (int c = 0; c < 2; c++) begin
        e_dout[m][c] = 0;
        since[m][c]  = H + 1;
      end
    end
  endtask

  task automatic model_edge();
    bit any;
    if (reset) begin
      model_reset();
      return;
    end
    e_dv = q1_v;
    for (int m = 0; m < 2; m++) begin
      any = 0;
      if (q1_v != 0) begin
        for (int c = 0; c < 2; c++) begin
          e_dout[m][c] = ref_out(m, q1_d[c]);
          if (ref_clip(m, q1_d[c])) begin
            since[m][c] = 0;
            any = 1;
          end else if (since[m][c] <= H) begin
            since[m][c]++;
          end
        end
      end
      if (any && e_cnt[m] < 15) e_cnt[m]++;
      if (clip_cnt_clr) e_cnt[m] = 0;
    end
    q1_v = din_valid;
    if (din_valid) begin
      q1_d[0] = int'(din[12:0]);
      q1_d[1] = int'(din[25:13]);
    end
  endtask

  task automatic check_all();
    int adv[2];
    int ad[2][2];
    int acl[2][2];
    int acn[2];
    adv[0] = int'(dv_u);          adv[1] = int'(dv_s);
    ad[0][0] = int'(do_u[11:0]);  ad[0][1] = int'(do_u[23:12]);
    ad[1][0] = int'(do_s[11:0]);  ad[1][1] = int'(do_s[23:12]);
    acl[0][0] = int'(clip_u[0]);  acl[0][1] = int'(clip_u[1]);
    acl[1][0] = int'(clip_s[0]);  acl[1][1] = int'(clip_s[1]);
    acn[0] = int'(cnt_u);         acn[1] = int'(cnt_s);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_dout_valid", m), adv[m], e_dv);
      chk($sformatf("m%0d_clip_cnt", m), acn[m], e_cnt[m]);
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("m%0d_dout_ch%0d", m, c), ad[m][c], e_dout[m][c]);
        chk($sformatf("m%0d_clip_ch%0d", m, c), acl[m][c], (since[m][c] <= H) ? 1 : 0);
      end
    end
  endtask

  task automatic step(input bit v, input int d0, input int d1,
                      input bit clr = 1'b0, input bit rst = 1'b0);
    @(negedge clk);
    reset        = rst;
    din_valid    = v;
    clip_cnt_clr = clr;
    din          = {d1[12:0], d0[12:0]};
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic int rnd13();
    int base;
    case ($urandom_range(0, 3))
      0: base = 2047;
      1: base = 4095;
      2: base = 6143;
      default: return int'($urandom_range(0, 8191));
    endcase
    return (base + int'($urandom_range(0, 4)) - 1) & 8191;
  endfunction

  typedef struct {
    int din;
    int exp_u;
    int exp_s;
  } vec_t;

  vec_t tab[NT];

  initial begin
    tab[0] = '{din: 'h0000, exp_u: 'h000, exp_s: 'h000};
    tab[1] = '{din: 'h0FFF, exp_u: 'hFFF, exp_s: 'h7FF};
    tab[2] = '{din: 'h1000, exp_u: 'hFFF, exp_s: 'h800};
    tab[3] = '{din: 'h0800, exp_u: 'h800, exp_s: 'h7FF};
    tab[4] = '{din: 'h07FF, exp_u: 'h7FF, exp_s: 'h7FF};
    tab[5] = '{din: 'h17FF, exp_u: 'hFFF, exp_s: 'h800};
    tab[6] = '{din: 'h1F00, exp_u: 'hFFF, exp_s: 'hF00};
    tab[7] = '{din: 'h1800, exp_u: 'hFFF, exp_s: 'h800};
    tab[8] = '{din: 'h1FFF, exp_u: 'hFFF, exp_s: 'hFFF};
    tab[9] = '{din: 'h0123, exp_u: 'h123, exp_s: 'h123};

    model_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_dout", int'(do_u), 0);
    chk("reset_dv", int'(dv_s), 0);
    chk("reset_clip", int'(clip_u), 0);
    chk("reset_cnt", int'(cnt_s), 0);

    // Table vectors: channel 1 walks the table backwards.
    for (int i = 0; i < NT; i++) begin
      step(1, tab[i].din, tab[NT-1-i].din);
      step(0, 0, 0);
      chk("tab_dv", int'(dv_u), 1);
      chk("tab_u_ch0", int'(do_u[11:0]),  tab[i].exp_u);
      chk("tab_u_ch1", int'(do_u[23:12]), tab[NT-1-i].exp_u);
      chk("tab_s_ch0", int'(do_s[11:0]),  tab[i].exp_s);
      chk("tab_s_ch1", int'(do_s[23:12]), tab[NT-1-i].exp_s);
    end

    // Unsigned single-vector clip.
    step(0, 0, 0, 0, 1);
    step(1, 'h0FFF, 'h1000);
    step(0, 0, 0);
    chk("uns_pair_dout", int'(do_u), 'hFFFFFF);
    chk("uns_pair_clip", int'(clip_u), 2);
    chk("uns_pair_cnt", int'(cnt_u), 1);

    // Signed back-to-back sequence.
    step(0, 0, 0, 0, 1);
    step(1, 'h0800, 0);
    step(1, 'h17FF, 0);
    step(1, 'h1F00, 0);
    step(1, 'h07FF, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("sgn_seq_cnt", int'(cnt_s), 2);
    chk("sgn_seq_last", int'(do_s[11:0]), 'h7FF);

    // Hold: idle cycles between samples must not age the flag.
    step(0, 0, 0, 0, 1);
    step(1, 'h1000, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("hold_idle", int'(clip_u[0]), 1);
    for (int k = 1; k <= 5; k++) begin
      step(1, 'h0010, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk($sformatf("hold_u_k%0d", k), int'(clip_u[0]), (k <= 4) ? 1 : 0);
      chk($sformatf("hold_s_k%0d", k), int'(clip_s[0]), (k <= 4) ? 1 : 0);
    end

    // Saturation and clear-beats-increment.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 'h1000, 'h1000);
    chk("sat_cnt", int'(cnt_u), 15);
    step(1, 'h1000, 'h1000, 1);
    chk("clr_prio", int'(cnt_u), 0);
    step(0, 0, 0);
    chk("after_clr", int'(cnt_s), 1);

    // Reset in the middle of a back-to-back burst.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 'h0F00 + i * 'h101, 'h1800 - i * 3, 0, i == 3);
      if (i == 3) begin
        chk("midrst_dv", int'(dv_u), 0);
        chk("midrst_dout", int'(do_s), 0);
        chk("midrst_clip", int'(clip_u), 0);
      end
      if (i == 4) chk("midrst_no_stray", int'(dv_s), 0);
    end
    step(0, 0, 0);
    step(0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rnd13(), rnd13(),
           $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
